// File: rtl/dac_mc_pkg.sv
// Shared types and helpers for the multi-channel PWM DAC.
// Holds the handshake FSM encoding, source-select encoding and counter range helper.
package dac_mc_pkg;

    typedef enum logic [0:0] {
        HS_IDLE = 1'b0,
        HS_ACK  = 1'b1
    } hs_state_t;

    localparam logic SRC_CPU = 1'b0;
    localparam logic SRC_WG  = 1'b1;

    // Top count of a WIDTH-bit counter (2^WIDTH - 1); the module turns this into CNT_MAX.
    function automatic int cnt_max(input int width);
        return (32'sd1 <<< width) - 32'sd1;
    endfunction

endpackage

// File: rtl/pwm_shadow_ch.sv
// One PWM channel: selects the pending duty source, loads it into the active
// register only on a frame wrap, and produces a registered compare output.
module pwm_shadow_ch
    import dac_mc_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wrap,
    input  logic             src,
    input  logic [WIDTH-1:0] wg_pend,
    input  logic [WIDTH-1:0] rv_pend,
    input  logic [WIDTH-1:0] cnt,
    output logic             pwm
);

    logic [WIDTH-1:0] pend_s;
    logic [WIDTH-1:0] active_r;
    logic             pwm_r;

    // Pending duty follows the synchronized source selection.
    always_comb begin
        pend_s = rv_pend;
        if (src == SRC_WG) begin
            pend_s = wg_pend;
        end else begin
            pend_s = rv_pend;
        end
    end

    // Shadow load: a new duty never lands mid-frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_r <= {WIDTH{1'b0}};
        end else if (wrap) begin
            active_r <= pend_s;
        end
    end

    // Registered compare keeps the output glitch-free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_r <= 1'b0;
        end else begin
            pwm_r <= (active_r > cnt);
        end
    end

    assign pwm = pwm_r;

endmodule

// File: rtl/dac_mc.sv
// Multi-channel PWM audio DAC: frame counter, CPU req/ack capture, FIFO sample
// fetch with underflow flag, and NCH double-buffered PWM channels.
module dac_mc
    import dac_mc_pkg::*;
#(
    parameter int NCH    = 2,
    parameter int WIDTH  = 12,
    parameter int CENTER = 0
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NCH-1:0]                           src_sel,
    input  logic                                     cpu_req,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cpu_ch,
    input  logic [WIDTH-1:0]                         cpu_duty,
    output logic                                     cpu_ack,
    input  logic [NCH*WIDTH-1:0]                     fifo_data,
    input  logic                                     fifo_empty,
    output logic                                     fifo_r_en,
    input  logic                                     underflow_clr,
    output logic                                     underflow,
    output logic                                     frame_start,
    output logic [NCH-1:0]                           pwm
);

    localparam int               CHW     = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(cnt_max(WIDTH));

    logic [WIDTH-1:0]            cnt_r;
    logic                        dir_down_r;
    logic                        wrap_s;
    logic                        frame_start_r;
    logic [NCH-1:0]              src_m_r;
    logic [NCH-1:0]              src_s;
    logic                        req_m_r;
    logic                        req_s;
    hs_state_t                   hs_state_r;
    hs_state_t                   hs_state_s;
    logic                        hs_cap_s;
    logic [NCH-1:0][WIDTH-1:0]   rv_pend_r;
    logic [NCH-1:0][WIDTH-1:0]   wg_pend_r;
    logic                        rd_d_r;
    logic                        underflow_r;
    logic                        any_wg_s;
    logic                        r_en_s;
    logic                        uf_set_s;

    // Wrap edge: last cycle of the frame for the selected counter shape.
    always_comb begin
        wrap_s = 1'b0;
        if (CENTER != 0) begin
            wrap_s = dir_down_r && (cnt_r == WIDTH'(1));
        end else begin
            wrap_s = (cnt_r == CNT_MAX);
        end
    end

    // Frame counter: sawtooth, or triangle that turns at CNT_MAX and at 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r      <= {WIDTH{1'b0}};
            dir_down_r <= 1'b0;
        end else if (CENTER == 0) begin
            cnt_r      <= cnt_r + WIDTH'(1);
            dir_down_r <= 1'b0;
        end else if (!dir_down_r) begin
            if (cnt_r == CNT_MAX) begin
                cnt_r      <= CNT_MAX - WIDTH'(1);
                dir_down_r <= 1'b1;
            end else begin
                cnt_r <= cnt_r + WIDTH'(1);
            end
        end else begin
            if (cnt_r == WIDTH'(1)) begin
                cnt_r      <= {WIDTH{1'b0}};
                dir_down_r <= 1'b0;
            end else begin
                cnt_r <= cnt_r - WIDTH'(1);
            end
        end
    end

    // Two-flop synchronizers for the asynchronous source select and request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_m_r <= {NCH{1'b0}};
            src_s   <= {NCH{1'b0}};
            req_m_r <= 1'b0;
            req_s   <= 1'b0;
        end else begin
            src_m_r <= src_sel;
            src_s   <= src_m_r;
            req_m_r <= cpu_req;
            req_s   <= req_m_r;
        end
    end

    // Handshake state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hs_state_r <= HS_IDLE;
        end else begin
            hs_state_r <= hs_state_s;
        end
    end

    // Handshake next state; capture fires on the IDLE->ACK transition only.
    always_comb begin
        hs_state_s = hs_state_r;
        hs_cap_s   = 1'b0;
        case (hs_state_r)
            HS_IDLE: begin
                if (req_s) begin
                    hs_state_s = HS_ACK;
                    hs_cap_s   = 1'b1;
                end else begin
                    hs_state_s = HS_IDLE;
                end
            end
            HS_ACK: begin
                if (!req_s) begin
                    hs_state_s = HS_IDLE;
                end else begin
                    hs_state_s = HS_ACK;
                end
            end
            default: begin
                hs_state_s = HS_IDLE;
            end
        endcase
    end

    // CPU pending duties; an out-of-range channel is acked but matches no slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rv_pend_r <= {(NCH*WIDTH){1'b0}};
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (hs_cap_s && (cpu_ch == CHW'(c))) begin
                    rv_pend_r[c] <= cpu_duty;
                end
            end
        end
    end

    assign any_wg_s = (src_s != {NCH{SRC_CPU}});
    assign r_en_s   = frame_start_r && !fifo_empty && any_wg_s;
    assign uf_set_s = frame_start_r && fifo_empty && any_wg_s;

    // Frame strobe, FIFO capture one cycle after the read, sticky underflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_start_r <= 1'b0;
            rd_d_r        <= 1'b0;
            wg_pend_r     <= {(NCH*WIDTH){1'b0}};
            underflow_r   <= 1'b0;
        end else begin
            frame_start_r <= wrap_s;
            rd_d_r        <= r_en_s;
            if (rd_d_r) begin
                wg_pend_r <= fifo_data;
            end
            if (uf_set_s) begin
                underflow_r <= 1'b1;
            end else if (underflow_clr) begin
                underflow_r <= 1'b0;
            end
        end
    end

    assign cpu_ack     = (hs_state_r == HS_ACK);
    assign fifo_r_en   = r_en_s;
    assign underflow   = underflow_r;
    assign frame_start = frame_start_r;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        pwm_shadow_ch #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .wrap   (wrap_s),
            .src    (src_s[c]),
            .wg_pend(wg_pend_r[c]),
            .rv_pend(rv_pend_r[c]),
            .cnt    (cnt_r),
            .pwm    (pwm[c])
        );
    end

endmodule

// File: tb/tb_dac_mc.sv
// Randomized frame-level bench for dac_mc (edge mode) plus a center-mode instance.
// Expected PWM patterns come from a per-frame model of pending/active duties.
module tb_dac_mc;

    localparam int NCH = 2;
    localparam int W   = 4;
    localparam int FR  = 16;
    localparam int NFR = 40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [1:0]     src_sel;
    logic           cpu_req;
    logic [0:0]     cpu_ch;
    logic [3:0]     cpu_duty;
    logic           cpu_ack;
    logic [7:0]     fifo_data;
    logic           fifo_empty;
    logic           fifo_r_en;
    logic           underflow_clr;
    logic           underflow;
    logic           frame_start;
    logic [1:0]     pwm;

    logic [1:0]     c_src_sel;
    logic           c_req;
    logic [0:0]     c_ch;
    logic [3:0]     c_duty;
    logic           c_ack;
    logic           c_r_en;
    logic           c_underflow;
    logic           c_frame_start;
    logic [1:0]     c_pwm;

    dac_mc #(.NCH(NCH), .WIDTH(W), .CENTER(0)) u_dut (
        .clk(clk), .rst(rst), .src_sel(src_sel), .cpu_req(cpu_req), .cpu_ch(cpu_ch),
        .cpu_duty(cpu_duty), .cpu_ack(cpu_ack), .fifo_data(fifo_data),
        .fifo_empty(fifo_empty), .fifo_r_en(fifo_r_en), .underflow_clr(underflow_clr),
        .underflow(underflow), .frame_start(frame_start), .pwm(pwm)
    );

    dac_mc #(.NCH(NCH), .WIDTH(W), .CENTER(1)) u_dut_ctr (
        .clk(clk), .rst(rst), .src_sel(c_src_sel), .cpu_req(c_req), .cpu_ch(c_ch),
        .cpu_duty(c_duty), .cpu_ack(c_ack), .fifo_data(fifo_data),
        .fifo_empty(fifo_empty), .fifo_r_en(c_r_en), .underflow_clr(underflow_clr),
        .underflow(c_underflow), .frame_start(c_frame_start), .pwm(c_pwm)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Edge mode: during one frame the output is high for count values below the duty.
    function automatic logic [15:0] epat(input logic [3:0] d);
        logic [15:0] p;
        for (int k = 0; k < FR; k++) p[k] = (k < int'(d));
        return p;
    endfunction

    // Center mode frame visits 0..max then max-1..1; count values below the duty.
    function automatic int ctr_high(input int d);
        int m;
        int n;
        m = (1 << W) - 1;
        n = 0;
        for (int v = 0; v <= m; v++) if (v < d) n++;
        for (int v = m - 1; v >= 1; v--) if (v < d) n++;
        return n;
    endfunction

    function automatic logic [3:0] pick_duty();
        int r;
        r = $urandom_range(0, 3);
        if (r == 0) return 4'd0;
        if (r == 1) return 4'd15;
        return 4'($urandom_range(0, 15));
    endfunction

    task automatic c_write(input logic ch, input logic [3:0] d);
        c_ch   = ch;
        c_duty = d;
        c_req  = 1'b1;
        for (int i = 0; i < 10 && !c_ack; i++) @(negedge clk);
        check_eq("c_ack_hi", c_ack, 1);
        c_req = 1'b0;
        for (int i = 0; i < 10 && c_ack; i++) @(negedge clk);
        check_eq("c_ack_lo", c_ack, 0);
    endtask

    task automatic wait_cfs(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!c_frame_start && n < 80);
        check_eq("c_fs_seen", c_frame_start, 1);
    endtask

    logic [3:0]  rv_m [NCH];
    logic [3:0]  wg_m [NCH];
    logic [3:0]  exp_cur [NCH];
    logic [3:0]  exp_prev [NCH];
    logic [15:0] pat_cur [NCH];
    logic [15:0] pat_prev [NCH];
    logic [1:0]  src_m;
    logic [7:0]  data_m;
    logic [3:0]  wr_duty, l_duty;
    logic        wr_ch, l_ch;
    bit          empty_m, uf_m, read_m, have_prev;
    bit          do_wr, late_now, late_pend, clr0, clr5;

    initial begin
        int n, per, h0, h1;
        logic mid;
        rst = 1'b0; src_sel = 2'b00; cpu_req = 1'b0; cpu_ch = 1'b0; cpu_duty = 4'd0;
        fifo_data = 8'd0; fifo_empty = 1'b1; underflow_clr = 1'b0;
        c_src_sel = 2'b00; c_req = 1'b0; c_ch = 1'b0; c_duty = 4'd0;
        for (int c = 0; c < NCH; c++) begin
            rv_m[c] = 4'd0; wg_m[c] = 4'd0;
        end
        src_m = 2'b00; empty_m = 1'b1; data_m = 8'd0; uf_m = 1'b0;
        have_prev = 1'b0; late_pend = 1'b0; late_now = 1'b0; do_wr = 1'b0;

        // Reset asserted mid-handshake with the request still high.
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        cpu_ch = 1'b1; cpu_duty = 4'd7; cpu_req = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("pre_rst_ack", cpu_ack, 1);
        #2 rst = 1'b0;
        #1;
        check_eq("rst_ack", cpu_ack, 0);
        check_eq("rst_ren", fifo_r_en, 0);
        check_eq("rst_uf", underflow, 0);
        check_eq("rst_fs", frame_start, 0);
        check_eq("rst_pwm", pwm, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("rel_ack_2", cpu_ack, 0);
        @(negedge clk);
        check_eq("rel_ack_3", cpu_ack, 1);
        rv_m[1] = 4'd7;
        cpu_req = 1'b0;
        for (int i = 0; i < 10 && cpu_ack; i++) @(negedge clk);
        check_eq("rel_ack_lo", cpu_ack, 0);

        for (int i = 0; i < 40 && !frame_start; i++) @(negedge clk);
        check_eq("sync_fs", frame_start, 1);
        for (int c = 0; c < NCH; c++) exp_cur[c] = rv_m[c];

        for (int it = 0; it <= NFR; it++) begin
            for (int k = 0; k < FR; k++) begin
                if (it == NFR && k > 0) break;
                if (k == 0) begin
                    if (have_prev) begin
                        for (int c = 0; c < NCH; c++) begin
                            pat_prev[c][15] = pwm[c];
                            check_eq($sformatf("pwm%0d_frame%0d", c, it), pat_prev[c], epat(exp_prev[c]));
                        end
                    end
                    read_m = !empty_m && (src_m != 2'b00);
                    clr0 = ($urandom_range(0, 3) == 0);
                    underflow_clr = clr0;
                    if (empty_m && src_m != 2'b00) uf_m = 1'b1;
                    else if (clr0) uf_m = 1'b0;
                    if (read_m) for (int c = 0; c < NCH; c++) wg_m[c] = data_m[c*W +: W];
                    if (late_pend) check_eq("late_ack_hi", cpu_ack, 1);
                end else begin
                    for (int c = 0; c < NCH; c++) pat_cur[c][k-1] = pwm[c];
                end
                check_eq("fs", frame_start, (k == 0));
                check_eq("ren", fifo_r_en, (k == 0) && read_m);
                case (k)
                    1: begin
                        underflow_clr = 1'b0;
                        check_eq("uf_start", underflow, uf_m);
                        if (late_pend) cpu_req = 1'b0;
                    end
                    2: begin
                        src_sel = 2'($urandom_range(0, 3));
                        src_m = src_sel;
                        fifo_empty = ($urandom_range(0, 3) == 0);
                        empty_m = fifo_empty;
                        fifo_data = 8'($urandom);
                        data_m = fifo_data;
                        do_wr = !late_pend && ($urandom_range(0, 3) != 0);
                        late_now = !late_pend && ($urandom_range(0, 3) == 0);
                    end
                    3: begin
                        if (late_pend) check_eq("late_ack_hold", cpu_ack, 1);
                        if (do_wr) begin
                            wr_ch = 1'($urandom_range(0, 1));
                            wr_duty = pick_duty();
                            cpu_ch = wr_ch; cpu_duty = wr_duty; cpu_req = 1'b1;
                        end
                    end
                    4: begin
                        if (late_pend) begin
                            check_eq("late_ack_lo", cpu_ack, 0);
                            late_pend = 1'b0;
                        end
                    end
                    5: begin
                        if (do_wr) check_eq("ack_2edges", cpu_ack, 0);
                        clr5 = ($urandom_range(0, 3) == 0);
                        if (clr5) begin
                            underflow_clr = 1'b1;
                            uf_m = 1'b0;
                        end
                    end
                    6: begin
                        underflow_clr = 1'b0;
                        if (do_wr) begin
                            check_eq("ack_3edges", cpu_ack, 1);
                            rv_m[wr_ch] = wr_duty;
                        end
                    end
                    7: begin
                        check_eq("uf_mid", underflow, uf_m);
                        if (do_wr) cpu_req = 1'b0;
                    end
                    9:  if (do_wr) check_eq("ack_hold", cpu_ack, 1);
                    10: if (do_wr) check_eq("ack_fall", cpu_ack, 0);
                    13: begin
                        if (late_now) begin
                            l_ch = 1'($urandom_range(0, 1));
                            l_duty = pick_duty();
                            cpu_ch = l_ch; cpu_duty = l_duty; cpu_req = 1'b1;
                        end
                    end
                    15: if (late_now) check_eq("late_ack_pre", cpu_ack, 0);
                    default: ;
                endcase
                @(negedge clk);
            end
            if (it < NFR) begin
                for (int c = 0; c < NCH; c++) begin
                    exp_prev[c] = exp_cur[c];
                    exp_cur[c]  = src_m[c] ? wg_m[c] : rv_m[c];
                    pat_prev[c] = pat_cur[c];
                end
                have_prev = 1'b1;
                // A capture on the wrap edge only reaches pending, so it misses this load.
                if (late_now) begin
                    rv_m[l_ch] = l_duty;
                    late_pend = 1'b1;
                    late_now = 1'b0;
                end
            end
        end
        cpu_req = 1'b0;
        underflow_clr = 1'b0;

        // Center-aligned instance: duty 5 on ch0, full-scale duty on ch1.
        c_write(1'b0, 4'd5);
        c_write(1'b1, 4'd15);
        wait_cfs(n);
        wait_cfs(n);
        per = 0; h0 = 0; h1 = 0;
        mid = c_pwm[0];
        do begin
            h0 += int'(c_pwm[0]);
            h1 += int'(c_pwm[1]);
            per++;
            @(negedge clk);
        end while (!c_frame_start && per < 80);
        check_eq("ctr_period", per, 2 * ((1 << W) - 1));
        check_eq("ctr_high5", h0, ctr_high(5));
        check_eq("ctr_high15", h1, ctr_high(15));
        check_eq("ctr_center", mid, (1 < 5));
        check_eq("ctr_uf", c_underflow, 0);
        check_eq("ctr_ren", c_r_en, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
